// File: rtl/tcam_match_encoder.sv
// tcam_match_encoder
// Captures a TCAM match vector on load and offers the address of every set
// bit, lowest first, over a valid/ready handshake. It also reports whether
// anything matched and how many entries matched. A one-cycle done pulse
// marks the end of each scan.

module tcam_match_encoder #(
  parameter int address_size = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [(1 << address_size)-1:0] match_in,
  input  logic                          load,
  output logic [address_size-1:0]       out_address,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          hit,
  output logic [address_size:0]         match_count
);

  localparam int ENTRIES = 1 << address_size;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [ENTRIES-1:0]        r_pending;
  logic [address_size:0]     r_match_count;
  logic                      r_hit;

  logic [ENTRIES-1:0]        w_low_bit;
  logic [address_size-1:0]   w_address;
  logic [address_size:0]     w_popcount;
  logic                      w_valid;
  logic                      w_transfer;
  logic                      w_accept_load;
  logic                      w_last;

  // Isolate the lowest set bit of the pending vector (two's-complement trick).
  assign w_low_bit = r_pending & (~r_pending + ENTRIES'(1));

  // Priority-encode the lowest set bit of pending; an empty vector yields 0.
  always_comb begin
    w_address = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_address = address_size'(i);
      end
    end
  end

  // Population count of the incoming vector, one bit wider than the address
  // so that an all-ones vector counts to ENTRIES without wrapping.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_popcount = w_popcount + {{address_size{1'b0}}, match_in[i]};
    end
  end

  assign w_valid       = (r_state == RUN) && (r_pending != '0);
  assign w_transfer    = w_valid && out_ready;
  assign w_accept_load = (r_state == IDLE) && load;
  assign w_last        = ((r_pending & ~w_low_bit) == '0);

  // State register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision: loads are honoured only in IDLE, DONE lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_next = (match_in != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_transfer && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Capture the vector and its statistics on an accepted load, and retire one
  // pending bit per completed handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending     <= '0;
      r_match_count <= '0;
      r_hit         <= 1'b0;
    end else if (w_accept_load) begin
      r_pending     <= match_in;
      r_match_count <= w_popcount;
      r_hit         <= |match_in;
    end else if (w_transfer) begin
      r_pending     <= r_pending & ~w_low_bit;
    end
  end

  assign out_address = w_address;
  assign out_valid   = w_valid;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign hit         = r_hit;
  assign match_count = r_match_count;

endmodule

// File: tb/tb_tcam_match_encoder.sv
// Directed testbench for tcam_match_encoder (address_size = 4).
// Inputs change and outputs are checked on the falling clock edge.

module tb_tcam_match_encoder;

  logic        clock;
  logic        reset;
  logic [15:0] match_in;
  logic        load;
  logic [3:0]  out_address;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        hit;
  logic [4:0]  match_count;

  int tests_run;
  int tests_failed;

  tcam_match_encoder #(.address_size(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .match_in    (match_in),
    .load        (load),
    .out_address (out_address),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
    .match_count (match_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Check the handshake outputs in one call.
  task automatic check_out(input string tag, input logic v, input logic [3:0] a,
                           input logic b, input logic d);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) check({tag, ".addr"}, {28'd0, out_address}, {28'd0, a});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    load      = 1'b0;
    match_in  = '0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clock);
    check_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    check("reset.addr", {28'd0, out_address}, 32'd0);
    check("reset.hit", {31'd0, hit}, 32'd0);
    check("reset.count", {27'd0, match_count}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Basic scan of 16'h0412; match_in changes afterwards must not matter
    match_in = 16'h0412; load = 1'b1; out_ready = 1'b1;
    step();
    load = 1'b0; match_in = 16'hFFFF;
    check_out("basic.a1", 1'b1, 4'd1, 1'b1, 1'b0);
    check("basic.count", {27'd0, match_count}, 32'd3);
    check("basic.hit", {31'd0, hit}, 32'd1);
    step();
    check_out("basic.a4", 1'b1, 4'd4, 1'b1, 1'b0);
    step();
    check_out("basic.a10", 1'b1, 4'd10, 1'b1, 1'b0);
    step();
    check_out("basic.done", 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    check_out("basic.idle", 1'b0, 4'd0, 1'b0, 1'b0);
    check("basic.count_hold", {27'd0, match_count}, 32'd3);
    check("basic.hit_hold", {31'd0, hit}, 32'd1);

    // Empty load
    match_in = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    check_out("empty.done", 1'b0, 4'd0, 1'b1, 1'b1);
    check("empty.hit", {31'd0, hit}, 32'd0);
    check("empty.count", {27'd0, match_count}, 32'd0);
    step();
    check_out("empty.idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Backpressure on 16'h8001
    match_in = 16'h8001; load = 1'b1; out_ready = 1'b0;
    step();
    load = 1'b0;
    check_out("bp.hold0", 1'b1, 4'd0, 1'b1, 1'b0);
    step();
    check_out("bp.hold1", 1'b1, 4'd0, 1'b1, 1'b0);
    step();
    check_out("bp.hold2", 1'b1, 4'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("bp.a15", 1'b1, 4'd15, 1'b1, 1'b0);
    check("bp.count", {27'd0, match_count}, 32'd2);
    step();
    check_out("bp.done", 1'b0, 4'd0, 1'b1, 1'b1);
    step();

    // Full vector
    match_in = 16'hFFFF; load = 1'b1;
    step();
    load = 1'b0;
    check("full.count", {27'd0, match_count}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_out($sformatf("full.a%0d", i), 1'b1, 4'(i), 1'b1, 1'b0);
      step();
    end
    check_out("full.done", 1'b0, 4'd0, 1'b1, 1'b1);
    step();

    // Load asserted during RUN and DONE is ignored
    match_in = 16'h0003; load = 1'b1;
    step();
    load = 1'b1; match_in = 16'hF000;
    check_out("ign.a0", 1'b1, 4'd0, 1'b1, 1'b0);
    step();
    check_out("ign.a1", 1'b1, 4'd1, 1'b1, 1'b0);
    check("ign.count_run", {27'd0, match_count}, 32'd2);
    step();
    check_out("ign.done", 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    load = 1'b0;
    check_out("ign.idle", 1'b0, 4'd0, 1'b0, 1'b0);
    check("ign.count", {27'd0, match_count}, 32'd2);
    step();

    // Reset in the middle of a scan
    match_in = 16'h00F0; load = 1'b1; out_ready = 1'b0;
    step();
    load = 1'b0;
    check_out("rst.a4", 1'b1, 4'd4, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("rst.a5", 1'b1, 4'd5, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_out("rst.async", 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst.count", {27'd0, match_count}, 32'd0);
    step();
    check_out("rst.held", 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_out("rst.nodone", 1'b0, 4'd0, 1'b0, 1'b0);
    match_in = 16'h0002; load = 1'b1;
    step();
    load = 1'b0;
    check_out("rst.a1", 1'b1, 4'd1, 1'b1, 1'b0);
    check("rst.count_new", {27'd0, match_count}, 32'd1);
    step();
    check_out("rst.done", 1'b0, 4'd0, 1'b1, 1'b1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
